// File: rtl/shreg_pkg.sv
// Shared types for the universal shift engine: op codes, FSM states and
// the op classification helper.
// Optional rotate support is selected by the SHREG_ROTATE_EN macro.
package shreg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ASR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True for ops that run the stepping datapath; everything else
  // (reserved codes, and rotates when they are compiled out) behaves as a no-op.
  function automatic logic op_is_shift(op_e op);
    logic res;
    res = 1'b0;
    case (op)
      OP_SHL, OP_SHR, OP_ASR: res = 1'b1;
`ifdef SHREG_ROTATE_EN
      OP_ROL, OP_ROR:         res = 1'b1;
`endif
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shreg_engine_if.sv
// Command/data bus of the shift engine. The master issues commands and the
// serial fill bit; the slave (the engine) returns handshake and status.
interface shreg_engine_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  import shreg_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_count, load_data, ser_in,
    input  cmd_ready, q, ser_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, load_data, ser_in,
    output cmd_ready, q, ser_out, busy, done
  );

endinterface

// File: rtl/shreg_step.sv
// Purely combinational single-step shifter: given the current word, the op
// and the fill bit, produce the next word and the expelled bit.
// Rotate cases exist only when SHREG_ROTATE_EN is defined.
module shreg_step
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] v,
  input  op_e              op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_v,
  output logic             out_bit
);

  // One shift/rotate step; unknown ops pass the word through.
  always_comb begin
    next_v  = v;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        next_v  = {v[WIDTH-2:0], ser_in};
        out_bit = v[WIDTH-1];
      end
      OP_SHR: begin
        next_v  = {ser_in, v[WIDTH-1:1]};
        out_bit = v[0];
      end
      OP_ASR: begin
        next_v  = {v[WIDTH-1], v[WIDTH-1:1]};
        out_bit = v[0];
      end
`ifdef SHREG_ROTATE_EN
      OP_ROL: begin
        next_v  = {v[WIDTH-2:0], v[WIDTH-1]};
        out_bit = v[WIDTH-1];
      end
      OP_ROR: begin
        next_v  = {v[0], v[WIDTH-1:1]};
        out_bit = v[0];
      end
`endif
      default: begin
        next_v  = v;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shreg_engine.sv
// Command-driven universal shift engine: LOAD, or repeat a shift/rotate op
// for a programmed count, one step per clock, with valid/ready handshake and
// busy/done status. Rotates are enabled by the SHREG_ROTATE_EN macro.
module shreg_engine
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  shreg_engine_if.slave  bus
);

  state_e           state;
  state_e           state_nxt;
  op_e              op_r;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q_r;
  logic             so_r;
  logic             done_r;
  logic             ready;
  logic             busy;
  logic             accept;
  logic             start_run;
  logic             last_step;
  logic [WIDTH-1:0] step_v;
  logic             step_bit;

  assign accept    = bus.cmd_valid && ready;
  assign start_run = accept && op_is_shift(bus.cmd_op) && (bus.cmd_count != '0);
  assign last_step = (remaining == CNT_W'(1));

  shreg_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .v       (q_r),
    .op      (op_r),
    .ser_in  (bus.ser_in),
    .next_v  (step_v),
    .out_bit (step_bit)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: enter RUN only for a real shift with a nonzero count.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_run) state_nxt = ST_RUN;
      ST_RUN:  if (last_step) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE, busy only in RUN.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_RUN:  busy  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath: command latch, step counter, data/serial registers, done pulse.
  // Zero-count shifts, reserved ops and LOAD all finish in IDLE with done
  // on the following cycle; ser_out moves only on real shift steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r       <= '0;
      so_r      <= 1'b0;
      done_r    <= 1'b0;
      remaining <= '0;
      op_r      <= OP_LOAD;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_run) begin
            op_r      <= bus.cmd_op;
            remaining <= bus.cmd_count;
          end else if (accept) begin
            done_r <= 1'b1;
            if (bus.cmd_op == OP_LOAD) q_r <= bus.load_data;
          end
        end
        ST_RUN: begin
          q_r       <= step_v;
          so_r      <= step_bit;
          remaining <= remaining - CNT_W'(1);
          if (last_step) done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.busy      = busy;
  assign bus.q         = q_r;
  assign bus.ser_out   = so_r;
  assign bus.done      = done_r;

endmodule
